// File: rtl/bitty_sequencer_pkg.sv
// Shared definitions for the bitty_core instruction sequencer: FSM state
// encoding, instruction width and state-class helpers.
package bitty_sequencer_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_EXEC     = 3'd4,
    ST_NEXT     = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERR      = 3'd7
  } state_t;

  // States in which an instruction is somewhere in flight.
  function automatic logic is_busy(input state_t s);
    return (s == ST_FETCH) || (s == ST_WAIT_MEM) || (s == ST_ISSUE) ||
           (s == ST_EXEC)  || (s == ST_NEXT);
  endfunction

  // States from which a start pulse launches a new program.
  function automatic logic can_start(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/bitty_watchdog.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT-1.
module bitty_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == LAST);

endmodule

// File: rtl/bitty_sequencer.sv
// Instruction sequencer for bitty_core: fetches words from a synchronous ROM
// between pc_start and pc_end, issues each to the core and awaits core_done.
module bitty_sequencer
  import bitty_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [ADDR_W-1:0]  pc_start,
  input  logic [ADDR_W-1:0]  pc_end,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic               core_run,
  output logic [INSTR_W-1:0] core_instruction,
  input  logic               core_done,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [ADDR_W-1:0]  pc,
  output logic [CNT_W-1:0]   retired
);

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    r_pc_end;
  logic [INSTR_W-1:0]   r_instr;
  logic [CNT_W-1:0]     r_retired;
  logic                 r_stop_pend;
  logic                 w_accept;
  logic                 w_wdog_clr;
  logic                 w_wdog_en;
  logic                 w_wdog_expired;

  assign w_accept   = can_start(r_state) && start;
  assign w_wdog_clr = (r_state == ST_ISSUE);
  assign w_wdog_en  = (r_state == ST_EXEC);

  bitty_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (w_wdog_clr),
    .en      (w_wdog_en),
    .expired (w_wdog_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    w_next   = r_state;
    mem_rd   = 1'b0;
    core_run = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd = 1'b1;
        w_next = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: w_next = ST_ISSUE;
      ST_ISSUE: begin
        core_run = 1'b1;
        w_next   = ST_EXEC;
      end
      ST_EXEC: begin
        // A done arriving on the expiry cycle still completes the instruction.
        if (core_done)           w_next = ST_NEXT;
        else if (w_wdog_expired) w_next = ST_ERR;
      end
      ST_NEXT: begin
        if ((r_pc == r_pc_end) || r_stop_pend || stop) w_next = ST_DONE;
        else                                           w_next = ST_FETCH;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= '0;
      r_pc_end    <= '0;
      r_instr     <= '0;
      r_retired   <= '0;
      r_stop_pend <= 1'b0;
    end else if (w_accept) begin
      // A stop arriving alongside the accepted start is deliberately dropped.
      r_pc        <= pc_start;
      r_pc_end    <= pc_end;
      r_retired   <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      if (is_busy(r_state) && stop) r_stop_pend <= 1'b1;
      case (r_state)
        ST_WAIT_MEM: r_instr <= mem_data;
        ST_EXEC: begin
          if (core_done && (r_retired != '1)) r_retired <= r_retired + 1'b1;
        end
        ST_NEXT: begin
          if (w_next == ST_FETCH) r_pc <= r_pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr         = r_pc;
  assign pc               = r_pc;
  assign core_instruction = r_instr;
  assign retired          = r_retired;
  assign busy             = is_busy(r_state);
  assign halted           = (r_state == ST_DONE);
  assign error            = (r_state == ST_ERR);

endmodule
